// File: rtl/mod_mul_ctrl.sv
// mod_mul_ctrl -- secp256k1 field multiplier front end.
//
// Computes Z = (X*Y) mod p, where p = 2^256 - 2^32 - 977. A bit-serial,
// MSB-first shift-add loop forms the 512-bit product. The product is handed
// to an external reduction block over its start/busy handshake. The
// reducer's 256-bit result is then brought into [0, p-1] with a single
// conditional subtraction.
//
// Ports
//   clk        rising-edge system clock
//   start      asynchronous active-low clear; held high to run one multiply
//   X, Y       256-bit operands, captured on the first edge after start rises
//   busy       high from the load until Z is valid
//   Z          256-bit fully reduced result, held while start stays high
//   red_start  start/clear to the reducer (low keeps the reducer in reset)
//   red_A      512-bit product presented to the reducer
//   red_busy   reducer busy flag
//   red_B      reducer result, < 2^256 but possibly >= p
module mod_mul_ctrl #(
  parameter logic [255:0] P_MOD =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         start,
  input  logic [255:0] X,
  input  logic [255:0] Y,
  output logic         busy,
  output logic [255:0] Z,
  output logic         red_start,
  output logic [511:0] red_A,
  input  logic         red_busy,
  input  logic [255:0] red_B
);

  // The operand load is the action taken on leaving IDLE. The first edge
  // with start high therefore both captures X/Y and enters MUL.
  typedef enum logic [2:0] {
    IDLE,
    MUL,
    RED_GO,
    RED_WAIT,
    FIX,
    DONE
  } state_t;

  state_t       state, n_state;
  logic [255:0] xr, n_xr;
  logic [255:0] yr, n_yr;
  logic [511:0] acc, n_acc;
  logic [7:0]   cnt, n_cnt;
  logic         seen, n_seen;
  logic         n_busy;
  logic [255:0] n_z;
  logic         n_red_start;
  logic [511:0] n_red_a;

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      seen      <= 1'b0;
      busy      <= 1'b0;
      Z         <= '0;
      red_start <= 1'b0;
      red_A     <= '0;
    end else begin
      state     <= n_state;
      xr        <= n_xr;
      yr        <= n_yr;
      acc       <= n_acc;
      cnt       <= n_cnt;
      seen      <= n_seen;
      busy      <= n_busy;
      Z         <= n_z;
      red_start <= n_red_start;
      red_A     <= n_red_a;
    end
  end

  always_comb begin
    n_state     = state;
    n_xr        = xr;
    n_yr        = yr;
    n_acc       = acc;
    n_cnt       = cnt;
    n_seen      = seen;
    n_busy      = busy;
    n_z         = Z;
    n_red_start = red_start;
    n_red_a     = red_A;

    unique case (state)
      IDLE: begin
        n_xr    = X;
        n_yr    = Y;
        n_acc   = '0;
        n_cnt   = 8'd255;
        n_busy  = 1'b1;
        n_state = MUL;
      end

      MUL: begin
        // The product fits in 512 bits, so the left shift never drops a
        // set bit.
        n_acc = {acc[510:0], 1'b0} + (yr[cnt] ? {256'b0, xr} : 512'b0);
        if (cnt == 8'd0) begin
          n_state = RED_GO;
        end else begin
          n_cnt = cnt - 8'd1;
        end
      end

      RED_GO: begin
        n_red_a     = acc;
        n_red_start = 1'b1;
        n_seen      = 1'b0;
        n_state     = RED_WAIT;
      end

      RED_WAIT: begin
        // red_busy still reads low for a while after red_start rises. Only
        // a fall that follows an observed rise marks completion.
        if (red_busy) begin
          n_seen = 1'b1;
        end else if (seen) begin
          n_state = FIX;
        end
      end

      FIX: begin
        // red_B < 2^256 < 2p, so at most one subtraction is needed.
        n_z         = (red_B >= P_MOD) ? (red_B - P_MOD) : red_B;
        n_red_start = 1'b0;
        n_state     = DONE;
      end

      DONE: begin
        n_busy = 1'b0;
      end

      default: begin
        n_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_mul_ctrl.sv
module tb_mod_mul_ctrl;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic         start;
  logic [255:0] X, Y;
  logic         busy;
  logic [255:0] Z;
  logic         red_start;
  logic [511:0] red_A;
  logic         red_busy;
  logic [255:0] red_B;

  always #5 clk = ~clk;

  mod_mul_ctrl #(.P_MOD(P)) dut (
    .clk      (clk),
    .start    (start),
    .X        (X),
    .Y        (Y),
    .busy     (busy),
    .Z        (Z),
    .red_start(red_start),
    .red_A    (red_A),
    .red_busy (red_busy),
    .red_B    (red_B)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [511:0] q_a[$];
  logic [511:0] q_z[$];

  int unsigned pre_dly;
  int unsigned hold_len;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural reducer. It keeps busy low for pre_dly edges after it sees
  // red_start, then holds busy high for hold_len edges. It then drops busy
  // with a value congruent to red_A and below 2^256. red_B holds garbage
  // until that point.
  int unsigned r_phase;
  int unsigned r_cnt;

  always @(posedge clk or negedge red_start) begin
    logic [511:0] v;
    if (!red_start) begin
      red_busy <= 1'b0;
      red_B    <= 256'hDEAD_BEEF;
      r_phase  <= 0;
      r_cnt    <= 0;
    end else begin
      case (r_phase)
        0: begin
          r_cnt <= 1;
          if (pre_dly == 0) begin
            red_busy <= 1'b1;
            r_phase  <= 2;
          end else begin
            r_phase <= 1;
          end
        end
        1: begin
          if (r_cnt == pre_dly) begin
            red_busy <= 1'b1;
            r_cnt    <= 1;
            r_phase  <= 2;
          end else begin
            r_cnt <= r_cnt + 1;
          end
        end
        2: begin
          if (r_cnt == hold_len) begin
            v = (red_A[511:256] == '0) ? red_A : (red_A % {256'b0, P});
            red_B    <= v[255:0];
            red_busy <= 1'b0;
            r_phase  <= 3;
          end else begin
            r_cnt <= r_cnt + 1;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                        input int unsigned d, input int unsigned h);
    logic [511:0] prod;
    int unsigned  edge_n;
    int unsigned  fall_edge;
    bit           got_go;
    prod = {256'b0, a} * {256'b0, b};
    q_a.push_back(prod);
    q_z.push_back(prod % {256'b0, P});
    @(negedge clk);
    X = a; Y = b; pre_dly = d; hold_len = h;
    start = 1'b1;
    #1 chk("busy_before_edge0", 512'(busy), 512'(0));
    @(posedge clk); #1;
    chk("busy_after_edge0", 512'(busy), 512'(1));
    X = rnd256();
    Y = rnd256();
    edge_n = 0; fall_edge = 0; got_go = 1'b0;
    while (edge_n < 2000) begin
      @(posedge clk); #1;
      edge_n++;
      if (!got_go && red_start) begin
        got_go = 1'b1;
        chk("red_go_edge", 512'(edge_n), 512'(257));
        chk("red_A", red_A, q_a.pop_front());
      end
      if (!busy) begin
        fall_edge = edge_n;
        break;
      end
    end
    if (!got_go) void'(q_a.pop_front());
    chk("red_go_seen", 512'(got_go), 512'(1));
    chk("latency", 512'(fall_edge), 512'(261 + d + h));
    chk("Z", {256'b0, Z}, q_z.pop_front());
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("Z_cleared", {256'b0, Z}, 512'(0));
    chk("red_start_cleared", 512'(red_start), 512'(0));
  endtask

  // Start an operation, then drop start shortly after edge n (counted from
  // edge 0) and check that the outputs clear without any clock edge.
  task automatic abort_at(input int unsigned n, input int unsigned d, input int unsigned h);
    @(negedge clk);
    X = rnd256(); Y = rnd256(); pre_dly = d; hold_len = h;
    start = 1'b1;
    @(posedge clk);
    repeat (n) @(posedge clk);
    #2 start = 1'b0;
    #1;
    chk("abort_busy", 512'(busy), 512'(0));
    chk("abort_red_start", 512'(red_start), 512'(0));
    chk("abort_Z", {256'b0, Z}, 512'(0));
    chk("abort_red_A", red_A, 512'(0));
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] big;
    start = 1'b0; X = '0; Y = '0; pre_dly = 0; hold_len = 9;
    #1 start = 1'b1;
    #1 start = 1'b0;
    #1;
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_Z", {256'b0, Z}, 512'(0));
    chk("rst_red_start", 512'(red_start), 512'(0));
    chk("rst_red_A", red_A, 512'(0));

    big = '0;
    big[128] = 1'b1;
    run_op(256'd2, 256'd3, 0, 17);
    run_op(P - 256'd1, P - 256'd1, 0, 25);
    run_op(big, big, 0, 9);
    run_op(256'd1, P + 256'd5, 0, 9);
    run_op(256'd1, P, 1, 9);
    run_op(256'd0, rnd256(), 3, 9);
    abort_at(100, 0, 17);
    run_op(256'd7, 256'd9, 0, 17);
    abort_at(259, 0, 20);
    run_op(rnd256(), rnd256(), 2, 17);
    run_op(rnd256(), rnd256(), 5, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
